// File: rtl/vol_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vol_pkg : shared state type, default sizing and pointer helpers for the
//           volatility sample-buffer scheduler.
// Rev 1.0
// ============================================================================
package vol_pkg;

   localparam int unsigned VOL_NUM_STOCKS  = 4;
   localparam int unsigned VOL_BUFFER_SIZE = 20;
   localparam int unsigned VOL_DATA_WIDTH  = 32;

   localparam int unsigned STOCK_W = $clog2(VOL_NUM_STOCKS);
   localparam int unsigned ADDR_W  = $clog2(VOL_NUM_STOCKS * VOL_BUFFER_SIZE);
   localparam int unsigned PTR_W   = $clog2(VOL_BUFFER_SIZE);
   localparam int unsigned CNT_W   = $clog2(VOL_BUFFER_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } vol_state_e;

   function automatic int unsigned region_base(input int unsigned stock,
                                               input int unsigned bsize = VOL_BUFFER_SIZE);
      return stock * bsize;
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned p,
                                            input int unsigned bsize = VOL_BUFFER_SIZE);
      return (p == bsize - 1) ? 0 : p + 1;
   endfunction

   function automatic int unsigned wrap_dec(input int unsigned p,
                                            input int unsigned bsize = VOL_BUFFER_SIZE);
      return (p == 0) ? bsize - 1 : p - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vol_ptr_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vol_ptr_bank : per-stock circular write pointers and saturating fill counts,
//                with a post-update view of one stock for sweep snapshots.
// Rev 1.0
// ============================================================================
module vol_ptr_bank
   import vol_pkg::*;
#(
   parameter  int unsigned NUM_STOCKS  = VOL_NUM_STOCKS,
   parameter  int unsigned BUFFER_SIZE = VOL_BUFFER_SIZE,
   localparam int unsigned STOCK_BITS  = $clog2(NUM_STOCKS),
   localparam int unsigned PTR_BITS    = $clog2(BUFFER_SIZE),
   localparam int unsigned CNT_BITS    = $clog2(BUFFER_SIZE + 1)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  upd_en_i,
   input  logic [STOCK_BITS-1:0] upd_stock_i,
   output logic [PTR_BITS-1:0]   upd_ptr_o,
   input  logic [STOCK_BITS-1:0] snap_stock_i,
   output logic [PTR_BITS-1:0]   snap_ptr_o,
   output logic [CNT_BITS-1:0]   snap_fill_o
);

   logic [PTR_BITS-1:0] ptr_q  [NUM_STOCKS];
   logic [CNT_BITS-1:0] fill_q [NUM_STOCKS];

   for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_stock
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            ptr_q[g]  <= '0;
            fill_q[g] <= '0;
         end else if (upd_en_i && (upd_stock_i == STOCK_BITS'(g))) begin
            ptr_q[g] <= PTR_BITS'(wrap_inc(32'(ptr_q[g]), BUFFER_SIZE));
            if (fill_q[g] != CNT_BITS'(BUFFER_SIZE)) begin
               fill_q[g] <= fill_q[g] + 1'b1;
            end
         end
      end
   end

   assign upd_ptr_o = ptr_q[upd_stock_i];

   // A write accepted this cycle to the snapshot stock is folded in here.
   always_comb begin
      snap_ptr_o  = ptr_q[snap_stock_i];
      snap_fill_o = fill_q[snap_stock_i];
      if (upd_en_i && (upd_stock_i == snap_stock_i)) begin
         snap_ptr_o = PTR_BITS'(wrap_inc(32'(ptr_q[snap_stock_i]), BUFFER_SIZE));
         if (fill_q[snap_stock_i] != CNT_BITS'(BUFFER_SIZE)) begin
            snap_fill_o = fill_q[snap_stock_i] + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vol_buf_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vol_buf_sched : single-port sample RAM scheduler, sample writes vs sweeps.
//                 VOL_SWEEP_NEWEST_FIRST_EN selects newest-first sweep order.
// Rev 1.0
// ============================================================================
module vol_buf_sched
   import vol_pkg::*;
#(
   parameter  int unsigned NUM_STOCKS  = VOL_NUM_STOCKS,
   parameter  int unsigned BUFFER_SIZE = VOL_BUFFER_SIZE,
   parameter  int unsigned DATA_WIDTH  = VOL_DATA_WIDTH,
   localparam int unsigned STOCK_BITS  = $clog2(NUM_STOCKS),
   localparam int unsigned ADDR_BITS   = $clog2(NUM_STOCKS * BUFFER_SIZE),
   localparam int unsigned PTR_BITS    = $clog2(BUFFER_SIZE),
   localparam int unsigned CNT_BITS    = $clog2(BUFFER_SIZE + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [STOCK_BITS-1:0] i_wr_stock_id,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_req,
   input  logic [STOCK_BITS-1:0] i_rd_stock_id,
   output logic                  o_rd_ack,
   output logic                  o_ram_en,
   output logic                  o_ram_we,
   output logic [ADDR_BITS-1:0]  o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata,
   output logic                  o_sweep_valid,
   output logic [DATA_WIDTH-1:0] o_sweep_data,
   output logic                  o_sweep_last,
   output logic [CNT_BITS-1:0]   o_sweep_count,
   output logic                  o_sweep_done,
   output logic                  o_busy
);

   vol_state_e            state_q, state_d;
   logic [STOCK_BITS-1:0] sw_stock_q, sw_stock_d;
   logic [PTR_BITS-1:0]   sw_ptr_q, sw_ptr_d;
   logic [CNT_BITS-1:0]   sw_count_q, sw_count_d;
   logic [CNT_BITS-1:0]   remain_q, remain_d;
   logic                  prev_wr_q, prev_wr_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                  ram_last_q, ram_last_d;
   logic                  beat_q, beat_d;
   logic                  beat_last_q, beat_last_d;

   logic                  wr_ready;
   logic                  wr_grant;
   logic [PTR_BITS-1:0]   upd_ptr;
   logic [PTR_BITS-1:0]   snap_ptr;
   logic [CNT_BITS-1:0]   snap_fill;
   logic [PTR_BITS-1:0]   start_ptr;
   logic [PTR_BITS-1:0]   next_ptr;

   vol_ptr_bank #(
      .NUM_STOCKS  (NUM_STOCKS),
      .BUFFER_SIZE (BUFFER_SIZE)
   ) u_ptr_bank (
      .clk_i        (i_clk),
      .reset_i      (i_reset),
      .upd_en_i     (wr_grant),
      .upd_stock_i  (i_wr_stock_id),
      .upd_ptr_o    (upd_ptr),
      .snap_stock_i (i_rd_stock_id),
      .snap_ptr_o   (snap_ptr),
      .snap_fill_o  (snap_fill)
   );

`ifdef VOL_SWEEP_NEWEST_FIRST_EN
   assign start_ptr = PTR_BITS'(wrap_dec(32'(snap_ptr), BUFFER_SIZE));
   assign next_ptr  = PTR_BITS'(wrap_dec(32'(sw_ptr_q), BUFFER_SIZE));
`else
   assign start_ptr = (snap_fill == CNT_BITS'(BUFFER_SIZE)) ? snap_ptr : '0;
   assign next_ptr  = PTR_BITS'(wrap_inc(32'(sw_ptr_q), BUFFER_SIZE));
`endif

   // After a granted write the following SWEEP cycle belongs to the read.
   always_comb begin
      wr_ready = 1'b0;
      case (state_q)
         IDLE:    wr_ready = 1'b1;
         SWEEP:   wr_ready = (i_wr_stock_id != sw_stock_q) && !prev_wr_q;
         DRAIN:   wr_ready = (i_wr_stock_id != sw_stock_q);
         default: wr_ready = 1'b0;
      endcase
      wr_ready = wr_ready && !i_reset;
      wr_grant = i_wr_valid && wr_ready;
   end

   always_comb begin
      state_d      = state_q;
      sw_stock_d   = sw_stock_q;
      sw_ptr_d     = sw_ptr_q;
      sw_count_d   = sw_count_q;
      remain_d     = remain_q;
      prev_wr_d    = wr_grant;
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_last_d   = 1'b0;
      beat_d       = ram_en_q && !ram_we_q;
      beat_last_d  = ram_last_q;
      o_rd_ack     = 1'b0;
      o_sweep_done = 1'b0;

      if (wr_grant) begin
         ram_en_d    = 1'b1;
         ram_we_d    = 1'b1;
         ram_addr_d  = ADDR_BITS'(region_base(32'(i_wr_stock_id), BUFFER_SIZE) + 32'(upd_ptr));
         ram_wdata_d = i_wr_data;
      end

      case (state_q)
         IDLE: begin
            if (i_rd_req && !i_reset) begin
               o_rd_ack = 1'b1;
               if (snap_fill == '0) begin
                  o_sweep_done = 1'b1;
               end else begin
                  state_d    = SWEEP;
                  sw_stock_d = i_rd_stock_id;
                  sw_count_d = snap_fill;
                  remain_d   = snap_fill;
                  sw_ptr_d   = start_ptr;
               end
            end
         end
         SWEEP: begin
            if (!wr_grant) begin
               ram_en_d   = 1'b1;
               ram_we_d   = 1'b0;
               ram_addr_d = ADDR_BITS'(region_base(32'(sw_stock_q), BUFFER_SIZE) + 32'(sw_ptr_q));
               sw_ptr_d   = next_ptr;
               remain_d   = remain_q - 1'b1;
               if (remain_q == CNT_BITS'(1)) begin
                  ram_last_d = 1'b1;
                  state_d    = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (beat_q && beat_last_q) begin
               o_sweep_done = 1'b1;
               sw_count_d   = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         sw_stock_q  <= '0;
         sw_ptr_q    <= '0;
         sw_count_q  <= '0;
         remain_q    <= '0;
         prev_wr_q   <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_last_q  <= 1'b0;
         beat_q      <= 1'b0;
         beat_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sw_stock_q  <= sw_stock_d;
         sw_ptr_q    <= sw_ptr_d;
         sw_count_q  <= sw_count_d;
         remain_q    <= remain_d;
         prev_wr_q   <= prev_wr_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_last_q  <= ram_last_d;
         beat_q      <= beat_d;
         beat_last_q <= beat_last_d;
      end
   end

   assign o_wr_ready    = wr_ready;
   assign o_ram_en      = ram_en_q;
   assign o_ram_we      = ram_we_q;
   assign o_ram_addr    = ram_addr_q;
   assign o_ram_wdata   = ram_wdata_q;
   assign o_sweep_valid = beat_q;
   assign o_sweep_data  = beat_q ? i_ram_rdata : '0;
   assign o_sweep_last  = beat_q && beat_last_q;
   assign o_sweep_count = sw_count_q;
   assign o_busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/vol_buf_sched.md
Name: vol_buf_sched

Overview:
Scheduler for the shared single-port volatility sample RAM, which holds NUM_STOCKS regions of BUFFER_SIZE entries each. It owns per-stock circular write pointers and fill counts, and accepts new samples from the market-data path. It serves "sweep" requests from the volatility engine: one request reads a stock's whole valid window, in order. It arbitrates the single RAM port between sample writes and sweep reads.

Parameters:
NUM_STOCKS, 4, number of stocks / RAM regions
BUFFER_SIZE, 20, entries per stock region
DATA_WIDTH, 32, sample width

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_wr_valid  in  1  sample write request
o_wr_ready  out  1  write accepted this cycle when high with i_wr_valid
i_wr_stock_id  in  $clog2(NUM_STOCKS)  target stock
i_wr_data  in  DATA_WIDTH  sample
i_rd_req  in  1  sweep request, held until o_rd_ack
i_rd_stock_id  in  $clog2(NUM_STOCKS)  stock to sweep
o_rd_ack  out  1  one-cycle pulse, sweep accepted
o_ram_en  out  1  RAM strobe (registered)
o_ram_we  out  1  1 = write (registered)
o_ram_addr  out  $clog2(NUM_STOCKS*BUFFER_SIZE)  RAM address (registered)
o_ram_wdata  out  DATA_WIDTH  RAM write data (registered)
i_ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after read strobe
o_sweep_valid  out  1  sweep beat valid
o_sweep_data  out  DATA_WIDTH  beat data (= i_ram_rdata)
o_sweep_last  out  1  final beat of sweep
o_sweep_count  out  $clog2(BUFFER_SIZE+1)  entries in current sweep, held from ack to done
o_sweep_done  out  1  one-cycle pulse, sweep complete
o_busy  out  1  FSM not IDLE

Behaviour:
- Reset: all ptr=0 and fill=0. FSM=IDLE. All outputs 0.
- Address = stock*BUFFER_SIZE + ptr. ptr wraps BUFFER_SIZE-1 -> 0. fill saturates at BUFFER_SIZE.
- A write is accepted when i_wr_valid && o_wr_ready. The RAM write is driven the next cycle. ptr and fill update at the accept edge.
- FSM states:
  - IDLE: o_wr_ready=1. On i_rd_req: pulse o_rd_ack and go to SWEEP. The snapshot is taken from post-update values, so it includes a write accepted the same cycle to the same stock. Snapshot contents: stock, count=fill, start = (fill==BUFFER_SIZE) ? ptr : 0.
  - IDLE, empty stock: if fill==0, o_rd_ack and o_sweep_done pulse in the same cycle. FSM stays in IDLE and produces no beats.
  - SWEEP: issue one read per granted cycle, from start, incrementing with wrap inside the region. Writes to the sweep stock are blocked (o_wr_ready=0).
  - SWEEP arbitration with other stocks: writes to other stocks share the port by strict alternation. A granted write forces the next cycle to the sweep; in the cycle after a sweep read, a pending write wins. With no pending write, the sweep issues every cycle. After the count-th read is issued, go to DRAIN.
  - DRAIN: arbitration as in SWEEP. Wait for the final beat; that beat carries o_sweep_last=1, and o_sweep_done pulses in the same cycle. Return to IDLE.
- Beat timing: o_sweep_valid is high exactly 1 cycle after each read strobe. Beats are contiguous only when no write interleaves.
- i_rd_req outside IDLE: not acked and not lost; it is served on return to IDLE.
- Reset mid-sweep: sweep aborted, no done/last, pointers cleared, RAM strobes cease immediately.
- Out-of-range stock ids: out of scope, must not occur.

Optional Feature:
VOL_SWEEP_NEWEST_FIRST_EN: when defined, sweeps start at ptr-1 (with wrap) and decrement, newest sample first. The snapshot still captures ptr after any same-cycle write. When not defined, sweeps run oldest-first as above. Count, last, done and arbitration are identical in both modes.

Decomposition:
- Package vol_pkg:
  - state enum (IDLE, SWEEP, DRAIN)
  - localparam widths: stock id, region address, pointer, count
  - function region_base(stock)
  - function wrap_inc / wrap_dec
- Sub-module vol_ptr_bank: per-stock ptr/fill registers, with a write-update port and a combinational read of post-update values for the snapshot.
- The FSM, arbiter and RAM output registers live in vol_buf_sched.

Test Plan:
- Stock 1 writes 0xA, 0xB, 0xC → RAM writes at addr 20, 21, 22. Then sweep stock 1 → reads 20, 21, 22, count=3, beats A, B, C, last on C, done with C.
- 21 writes to stock 2 → 21st write goes to addr 40, fill=20. Sweep → 20 reads 41..59 then 40, last on addr 40 data. With VOL_SWEEP_NEWEST_FIRST_EN: 40, 59, ..., 41.
- Sweep stock 3 with no samples → ack and done same cycle, no o_sweep_valid, o_busy stays 0.
- Sweep stock 0 (5 entries) with continuous stock-1 writes → RAM alternates read/write. Stock-0 writes see o_wr_ready=0 until done. Sweep completes in 10 port cycles.
- Write to stock 0 in the same cycle as the stock-0 sweep request (fill was 4) → count=5, the new sample is the final beat.
- Assert i_reset during beat 2 of a 5-entry sweep → outputs 0 immediately, no done. Subsequent sweep of that stock is empty.
